alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter DEPTH, default 2, result-queue entries; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream operation present.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 in_op1  input  32  operand A.
REQ-007 in_op2  input  32  operand B; shift amount is in_op2[4:0].
REQ-008 in_ctrl  input  3  ALU operation select.
REQ-009 in_rd  input  5  destination register tag, carried through unchanged.
REQ-010 flush  input  1  discard all queued results.
REQ-011 out_valid  output  1  head result available.
REQ-012 out_ready  input  1  downstream accepts head result.
REQ-013 out_result  output  32  head result value.
REQ-014 out_rd  output  5  head destination tag.
REQ-015 out_zero  output  1  head result == 0.
REQ-016 op_count  output  16  number of results popped since reset/flush.

Function
REQ-017 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (occupancy < DEPTH), combinational from registered occupancy only; a pop in the same cycle SHALL NOT raise in_ready.
REQ-019 On push, the stage SHALL compute the result combinationally from in_op1/in_op2/in_ctrl and write {result, in_rd, zero} into the queue tail.
REQ-020 in_ctrl encoding SHALL be: 000 op1+op2; 001 op1-op2; 010 op1&op2; 011 op1|op2; 100 (op1<=op2) unsigned ? 1 : 0; 101 (op1<op2) unsigned ? 1 : 0; 110 op1<<op2[4:0]; 111 op1>>op2[4:0] logical.
REQ-021 Add/subtract SHALL be modulo 2^32; carry/borrow discarded; op2[31:5] SHALL be ignored for shifts.
REQ-022 Latency SHALL be 1 cycle: a push into an empty queue at edge N SHALL give out_valid=1 with that result after edge N.
REQ-023 Results SHALL leave in push order; out_result/out_rd/out_zero SHALL be stable while out_valid && !out_ready.
REQ-024 Simultaneous push and pop with 0 < occupancy < DEPTH SHALL leave occupancy unchanged and both operations SHALL take effect.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-026 out_valid SHALL equal (occupancy != 0); when 0, out_result/out_rd/out_zero SHALL be 0.
REQ-027 op_count SHALL increment by 1 per pop, wrapping 0xFFFF -> 0x0000.
REQ-028 flush SHALL, at the next edge, empty the queue, reset pointers, and clear op_count; any push or pop presented in the flush cycle SHALL be discarded and SHALL NOT count.

Reset
REQ-029 While rst_n=0 at an edge: occupancy=0, pointers=0, op_count=0; thus out_valid=0, in_ready=1, out_result=0, out_rd=0, out_zero=0.
REQ-030 Reset SHALL take priority over flush, push and pop; an operation in flight SHALL be lost.
REQ-031 Queue storage contents need not be cleared by reset; outputs SHALL still read 0 while empty.

Verification
REQ-032 Basic add: push op1=5, op2=7, ctrl=000, rd=3 into empty stage -> next cycle out_valid=1, out_result=12, out_rd=3, out_zero=0.
REQ-033 Wrap/zero: push op1=0xFFFFFFFF, op2=1, ctrl=000 -> out_result=0, out_zero=1; push op1=0, op2=1, ctrl=001 -> out_result=0xFFFFFFFF.
REQ-034 Backpressure/full: out_ready=0, push 2 ops (DEPTH=2) -> in_ready=0; third in_valid not accepted; raise out_ready -> results in order, in_ready=1 after first pop edge.
REQ-035 All ctrl codes with op1=0x80000001, op2=0x00000021: sll gives 0x00000002, srl gives 0x40000000, slt gives 0, slte gives 0, and gives 0x00000001, or gives 0x80000021.
REQ-036 Flush mid-stream with simultaneous push and pop -> next cycle out_valid=0, op_count=0, pushed op absent.
REQ-037 rst_n=0 for 1 cycle with 2 queued results -> out_valid=0, in_ready=1, op_count=0 after the edge.

Source files
------------

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Single-cycle ALU execute stage feeding a small result queue
//                with valid/ready handshakes on both sides, a flush that
//                discards queued results, and a popped-result counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    input  logic [2:0]  in_ctrl,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_zero,
    output logic [15:0] op_count
);

    // Pointer width indexes DEPTH entries; the occupancy counter must also hold DEPTH itself.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_AND  = 3'b010;
    localparam logic [2:0] C_OP_OR   = 3'b011;
    localparam logic [2:0] C_OP_SLTE = 3'b100;
    localparam logic [2:0] C_OP_SLT  = 3'b101;
    localparam logic [2:0] C_OP_SLL  = 3'b110;
    localparam logic [2:0] C_OP_SRL  = 3'b111;

    // Result storage is deliberately not reset; the output mux hides it while empty.
    logic [31:0]   mem_result [DEPTH];
    logic [4:0]    mem_rd     [DEPTH];
    logic          mem_zero   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [15:0]   op_count_q, op_count_d;

    logic [31:0]   w_result;
    logic          w_push;
    logic          w_pop;

    // ALU datapath: purely combinational from the incoming operands.
    always_comb begin
        w_result = 32'd0;
        case (in_ctrl)
            C_OP_ADD:  w_result = in_op1 + in_op2;
            C_OP_SUB:  w_result = in_op1 - in_op2;
            C_OP_AND:  w_result = in_op1 & in_op2;
            C_OP_OR:   w_result = in_op1 | in_op2;
            C_OP_SLTE: w_result = (in_op1 <= in_op2) ? 32'd1 : 32'd0;
            C_OP_SLT:  w_result = (in_op1 <  in_op2) ? 32'd1 : 32'd0;
            C_OP_SLL:  w_result = in_op1 << in_op2[4:0];
            C_OP_SRL:  w_result = in_op1 >> in_op2[4:0];
            default:   w_result = 32'd0;
        endcase
    end

    // Handshakes; ready depends only on registered occupancy, and flush voids both sides.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid  && in_ready  && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // Next-state for pointers, occupancy and pop counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        op_count_d = op_count_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            op_count_d = 16'd0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d   = rd_ptr_q + AW'(1);
                op_count_d = op_count_q + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_count_q <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_count_q <= op_count_d;
        end
    end

    // Write the computed entry at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_result[wr_ptr_q] <= w_result;
            mem_rd[wr_ptr_q]     <= in_rd;
            mem_zero[wr_ptr_q]   <= (w_result == 32'd0);
        end
    end

    // Head outputs are forced to zero whenever the queue is empty.
    always_comb begin
        out_result = 32'd0;
        out_rd     = 5'd0;
        out_zero   = 1'b0;
        if (out_valid) begin
            out_result = mem_result[rd_ptr_q];
            out_rd     = mem_rd[rd_ptr_q];
            out_zero   = mem_zero[rd_ptr_q];
        end
    end

    assign op_count = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_stage
//  Description : Scoreboard bench for alu_exec_stage; expected entries are
//                queued at the accepted push and compared at the head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [2:0]  in_ctrl;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_zero;
    logic [15:0] op_count;

    alu_exec_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_ctrl    (in_ctrl),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_zero   (out_zero),
        .op_count   (op_count)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } sb_t;

    sb_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pend_res;
    logic [4:0]  pend_rd;
    logic [15:0] exp_opcnt;
    bit          model_live = 0;
    bit          did_push   = 0;
    bit          rand_done  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return (a <= b) ? 32'd1 : 32'd0;
            3'd5:    return (a <  b) ? 32'd1 : 32'd0;
            3'd6:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // Monitor: check current outputs against the model, then advance the model.
    always @(negedge clk) begin
        bit  m_push;
        bit  m_pop;
        sb_t e;
        did_push = 0;
        if (model_live) begin
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            check_eq("in_ready",  {31'd0, in_ready},  {31'd0, sb.size() < DEPTH});
            check_eq("op_count",  {16'd0, op_count},  {16'd0, exp_opcnt});
            if (sb.size() != 0) begin
                check_eq("out_result", out_result, sb[0].res);
                check_eq("out_rd",     {27'd0, out_rd}, {27'd0, sb[0].rd});
                check_eq("out_zero",   {31'd0, out_zero}, {31'd0, sb[0].res == 32'd0});
            end else begin
                check_eq("empty_result", out_result, 32'd0);
                check_eq("empty_rd",     {27'd0, out_rd}, 32'd0);
                check_eq("empty_zero",   {31'd0, out_zero}, 32'd0);
            end
        end
        if (!rst_n) begin
            sb.delete();
            exp_opcnt  = 16'd0;
            model_live = 1;
        end else if (model_live) begin
            if (flush) begin
                sb.delete();
                exp_opcnt = 16'd0;
            end else begin
                m_pop  = (sb.size() != 0) && out_ready;
                m_push = (sb.size() < DEPTH) && in_valid;
                if (m_pop) begin
                    void'(sb.pop_front());
                    exp_opcnt = exp_opcnt + 16'd1;
                end
                if (m_push) begin
                    e.res = pend_res;
                    e.rd  = pend_rd;
                    sb.push_back(e);
                    did_push = 1;
                end
            end
        end
    end

    // Present one operation and hold it until the model records its acceptance.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                        input logic [4:0] rd, input logic [31:0] exp);
        int waited = 0;
        in_op1   = a;
        in_op2   = b;
        in_ctrl  = c;
        in_rd    = rd;
        pend_res = exp;
        pend_rd  = rd;
        in_valid = 1'b1;
        do begin
            @(posedge clk);
            waited++;
        end while (!did_push && waited < 200);
        if (!did_push) check_eq("push_timeout", 32'd0, 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op1    = '0;
        in_op2    = '0;
        in_ctrl   = '0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        pend_res  = '0;
        pend_rd   = '0;
        exp_opcnt = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Basic add and modulo/zero cases
        send(32'd5, 32'd7, 3'b000, 5'd3, 32'd12);
        idle(2);
        send(32'hFFFF_FFFF, 32'd1, 3'b000, 5'd4, 32'd0);
        send(32'd0, 32'd1, 3'b001, 5'd5, 32'hFFFF_FFFF);
        idle(2);

        // Every control code with the same operand pair
        send(32'h8000_0001, 32'h0000_0021, 3'd0, 5'd10, 32'h8000_0022);
        send(32'h8000_0001, 32'h0000_0021, 3'd1, 5'd11, 32'h7FFF_FFE0);
        send(32'h8000_0001, 32'h0000_0021, 3'd2, 5'd12, 32'h0000_0001);
        send(32'h8000_0001, 32'h0000_0021, 3'd3, 5'd13, 32'h8000_0021);
        send(32'h8000_0001, 32'h0000_0021, 3'd4, 5'd14, 32'h0000_0000);
        send(32'h8000_0001, 32'h0000_0021, 3'd5, 5'd15, 32'h0000_0000);
        send(32'h8000_0001, 32'h0000_0021, 3'd6, 5'd16, 32'h0000_0002);
        send(32'h8000_0001, 32'h0000_0021, 3'd7, 5'd17, 32'h4000_0000);
        send(32'h0000_0021, 32'h0000_0021, 3'd4, 5'd18, 32'h0000_0001);
        send(32'h0000_0021, 32'h0000_0021, 3'd5, 5'd19, 32'h0000_0000);
        idle(2);

        // Backpressure: fill, stall a third op, then release
        out_ready = 1'b0;
        send(32'd1, 32'd2, 3'b000, 5'd20, 32'd3);
        send(32'd9, 32'd4, 3'b001, 5'd21, 32'd5);
        fork
            send(32'hF0, 32'h0F, 3'b011, 5'd22, 32'hFF);
            begin
                idle(4);
                out_ready = 1'b1;
            end
        join
        idle(3);

        // Random traffic with random downstream stalls
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a, b;
                    logic [2:0]  c;
                    a = $urandom();
                    b = (i % 5 == 0) ? a : $urandom();
                    c = 3'($urandom_range(0, 7));
                    send(a, b, c, 5'($urandom_range(0, 31)), alu_model(a, b, c));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        idle(3);

        // Flush with simultaneous push and pop
        out_ready = 1'b0;
        send(32'd100, 32'd1, 3'b000, 5'd7, 32'd101);
        in_op1   = 32'd2;
        in_op2   = 32'd2;
        in_ctrl  = 3'b000;
        in_rd    = 5'd8;
        pend_res = 32'd4;
        pend_rd  = 5'd8;
        in_valid = 1'b1;
        out_ready = 1'b1;
        flush    = 1'b1;
        idle(1);
        in_valid = 1'b0;
        flush    = 1'b0;
        idle(2);

        // Reset with two queued results
        out_ready = 1'b0;
        send(32'd6, 32'd6, 3'b001, 5'd1, 32'd0);
        send(32'd6, 32'd1, 3'b110, 5'd2, 32'd12);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        out_ready = 1'b1;
        send(32'd3, 32'd4, 3'b000, 5'd9, 32'd7);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
